core_mem_responder: RTL

- Memory-side responder for the core's fetch and load/store port.
- Accepts one request at a time from the core through a valid/ready handshake.
- Models a word-addressed synchronous RAM with a programmable access latency and byte-strobe writes.
- Returns read data or an error flag through a response valid/ready handshake. Serves as both the instruction memory and the data memory in simulation and FPGA builds.

---
 rtl/core_mem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/core_mem_responder.sv
// Memory-side responder for the core fetch/load-store port: one outstanding request,
// programmable access latency, byte-strobe writes and range/alignment error reporting.
module core_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [3:0]  REQ_WSTRB,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] wdata_reg;
    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic        rsp_err_reg;
    logic [31:0] rsp_rdata_reg;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            single_lane;
    logic                  range_err;
    logic                  strb_legal;
    logic                  access_now;
    logic                  mem_wr;
    logic [3:0]            lane_we;

    always_comb begin
        word_idx    = addr_reg[ADDR_WIDTH+1:2];
        range_err   = (addr_reg >> (ADDR_WIDTH + 2)) != 32'd0;
        single_lane = 4'b0001 << addr_reg[1:0];
        strb_legal  = 1'b0;
        if (wstrb_reg == 4'b0000)
            strb_legal = 1'b1;
        else if (wstrb_reg == 4'b1111 || wstrb_reg == 4'b0011)
            strb_legal = (addr_reg[1:0] == 2'b00);
        else if (wstrb_reg == 4'b1100)
            strb_legal = (addr_reg[1:0] == 2'b10);
        else if (wstrb_reg == single_lane)
            strb_legal = 1'b1;
        access_now = (state_reg == WAIT) && (cnt_reg == 4'd0);
        // Gating with RST guarantees a write interrupted by reset never lands.
        mem_wr     = RST && access_now && we_reg && !range_err && strb_legal;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_we[gi] = mem_wr && wstrb_reg[gi];
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i])
                mem[word_idx][8*i +: 8] <= wdata_reg[8*i +: 8];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (REQ_VALID) begin
                        we_reg        <= REQ_WE;
                        addr_reg      <= REQ_ADDR;
                        wstrb_reg     <= REQ_WSTRB;
                        wdata_reg     <= REQ_WDATA;
                        cnt_reg       <= CNT_LOAD;
                        req_ready_reg <= 1'b0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        if (range_err) begin
                            rsp_rdata_reg <= 32'd0;
                            rsp_err_reg   <= 1'b1;
                        end else if (!we_reg) begin
                            rsp_rdata_reg <= mem[word_idx];
                            rsp_err_reg   <= 1'b0;
                        end else begin
                            rsp_rdata_reg <= 32'd0;
                            rsp_err_reg   <= !strb_legal;
                        end
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_rdata_reg <= 32'd0;
                        rsp_err_reg   <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign REQ_READY = req_ready_reg;
    assign RSP_VALID = rsp_valid_reg;
    assign RSP_RDATA = rsp_rdata_reg;
    assign RSP_ERR   = rsp_err_reg;

endmodule
